// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - Clause 22 MDIO management master with built-in MDC divider
//
// Purpose: accepts one read/write command at a time, generates MDC from clk and
// serialises PRE/ST/OP/PHYAD/REGAD/TA/DATA plus one trailing idle bit onto the
// MDIO pad, returning read data and a turnaround error flag on completion.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   cmd_valid/ready     command handshake; ready only while idle
//   cmd_write           1 = write frame, 0 = read frame
//   cmd_phyad/regad     PHY and register address
//   cmd_wdata           write data
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata/rsp_err   read data and TA error, held until the next completion
//   busy                frame in progress
//   mdc                 management clock (flop driven, idle low)
//   mdio_o/mdio_t/i     pad output, release (1 = released), pad input
module mdio_master #(
  parameter int CLK_DIV = 25,
  parameter int PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phyad,
  input  logic [4:0]  cmd_regad,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_ST   = 3'd2;
  localparam logic [2:0] S_OP   = 3'd3;
  localparam logic [2:0] S_ADDR = 3'd4;
  localparam logic [2:0] S_TA   = 3'd5;
  localparam logic [2:0] S_DATA = 3'd6;
  localparam logic [2:0] S_TAIL = 3'd7;

  // With preamble suppression the frame opens directly with the start bits.
  localparam logic [2:0] S_FIRST   = (PRE_LEN == 0) ? S_ST : S_PRE;
  localparam logic [5:0] FIRST_CNT = (PRE_LEN == 0) ? 6'd1 : 6'(PRE_LEN - 1);

  logic [2:0]       state_q, state_d, nxt_state;
  logic [5:0]       cnt_q, cnt_d, nxt_cnt;
  logic [DIV_W-1:0] div_q, div_d;
  logic             mdc_q, mdc_d;
  logic             mdo_q, mdo_d;
  logic             mdt_q, mdt_d;
  logic             wr_q, wr_d;
  logic [9:0]       addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [15:0]      rx_q, rx_d;
  logic             ta_err_q, ta_err_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [15:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  // Pad value {release, level} for bit index c (counting down) of state st.
  function automatic logic [1:0] drive(input logic [2:0] st, input logic [5:0] c,
                                       input logic wr, input logic [9:0] ad,
                                       input logic [15:0] wd);
    logic [1:0] r;
    case (st)
      S_PRE:   r = 2'b01;
      S_ST:    r = {1'b0, c == 6'd0};
      S_OP:    r = {1'b0, wr ? (c == 6'd0) : (c == 6'd1)};
      S_ADDR:  r = {1'b0, ad[c[3:0]]};
      S_TA:    r = wr ? {1'b0, c == 6'd1} : 2'b11;
      S_DATA:  r = wr ? {1'b0, wd[c[3:0]]} : 2'b11;
      default: r = 2'b11;
    endcase
    return r;
  endfunction

  // Field sequencing: the shared counter is reloaded on every state entry.
  always_comb begin
    nxt_state = S_IDLE;
    nxt_cnt   = 6'd0;
    case (state_q)
      S_PRE:   begin nxt_state = S_ST;   nxt_cnt = 6'd1;  end
      S_ST:    begin nxt_state = S_OP;   nxt_cnt = 6'd1;  end
      S_OP:    begin nxt_state = S_ADDR; nxt_cnt = 6'd9;  end
      S_ADDR:  begin nxt_state = S_TA;   nxt_cnt = 6'd1;  end
      S_TA:    begin nxt_state = S_DATA; nxt_cnt = 6'd15; end
      S_DATA:  begin nxt_state = S_TAIL; nxt_cnt = 6'd0;  end
      default: begin nxt_state = S_IDLE; nxt_cnt = 6'd0;  end
    endcase
    if (cnt_q != 6'd0) begin
      nxt_state = state_q;
      nxt_cnt   = cnt_q - 6'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    mdc_d       = mdc_q;
    mdo_d       = mdo_q;
    mdt_d       = mdt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rx_d        = rx_q;
    ta_err_d    = ta_err_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    if (state_q == S_IDLE) begin
      div_d = '0;
      mdc_d = 1'b0;
      mdt_d = 1'b1;
      mdo_d = 1'b1;
      if (cmd_valid && cmd_ready) begin
        wr_d     = cmd_write;
        addr_d   = {cmd_phyad, cmd_regad};
        wdata_d  = cmd_wdata;
        rx_d     = '0;
        ta_err_d = 1'b0;
        state_d  = S_FIRST;
        cnt_d    = FIRST_CNT;
        {mdt_d, mdo_d} = drive(S_FIRST, FIRST_CNT, cmd_write,
                               {cmd_phyad, cmd_regad}, cmd_wdata);
      end
    end else if (div_q != DIV_LAST) begin
      div_d = div_q + DIV_W'(1);
    end else begin
      div_d = '0;
      if (!mdc_q) begin
        // Last low cycle: capture the PHY's bit just before MDC rises.
        mdc_d = 1'b1;
        if (!wr_q && state_q == S_TA && cnt_q == 6'd0) ta_err_d = mdio_i;
        if (!wr_q && state_q == S_DATA) rx_d = {rx_q[14:0], mdio_i};
      end else begin
        // End of bit: MDC falls and the next bit's pad value goes out together.
        mdc_d   = 1'b0;
        state_d = nxt_state;
        cnt_d   = nxt_cnt;
        {mdt_d, mdo_d} = drive(nxt_state, nxt_cnt, wr_q, addr_q, wdata_q);
        if (state_q == S_TAIL) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = wr_q ? 16'h0000 : rx_q;
          rsp_err_d   = !wr_q && ta_err_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      mdc_q       <= 1'b0;
      mdo_q       <= 1'b1;
      mdt_q       <= 1'b1;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rx_q        <= '0;
      ta_err_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      mdc_q       <= mdc_d;
      mdo_q       <= mdo_d;
      mdt_q       <= mdt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rx_q        <= rx_d;
      ta_err_q    <= ta_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mdc       = mdc_q;
  assign mdio_o    = mdo_q;
  assign mdio_t    = mdt_q;

endmodule

// File: tb/tb_mdio_master.sv
// tb/tb_mdio_master.sv - randomized self-checking bench for mdio_master
module tb_mdio_master;

  localparam int D0 = 2;
  localparam int P0 = 32;
  localparam int D1 = 3;
  localparam int P1 = 0;
  localparam logic [4:0] PHY_ADDR = 5'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]       cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_err, busy;
  logic [1:0]       mdc, mdio_o, mdio_t, mdio_i;
  logic [1:0][4:0]  cmd_phyad, cmd_regad;
  logic [1:0][15:0] cmd_wdata, rsp_rdata;

  logic [15:0] regs [2][32];
  logic [15:0] last_rd [2];
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mdio_master #(.CLK_DIV(D0), .PRE_LEN(P0)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_write(cmd_write[0]), .cmd_phyad(cmd_phyad[0]), .cmd_regad(cmd_regad[0]),
    .cmd_wdata(cmd_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0]), .mdc(mdc[0]), .mdio_o(mdio_o[0]),
    .mdio_t(mdio_t[0]), .mdio_i(mdio_i[0]));

  mdio_master #(.CLK_DIV(D1), .PRE_LEN(P1)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_write(cmd_write[1]), .cmd_phyad(cmd_phyad[1]), .cmd_regad(cmd_regad[1]),
    .cmd_wdata(cmd_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1]), .mdc(mdc[1]), .mdio_o(mdio_o[1]),
    .mdio_t(mdio_t[1]), .mdio_i(mdio_i[1]));

  function automatic int div_of(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  function automatic int pre_of(input int i);
    return (i == 0) ? P0 : P1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic present(input int i, input logic wr, input logic [4:0] pa,
                         input logic [4:0] ra, input logic [15:0] wd);
    int n;
    @(negedge clk);
    cmd_write[i] = wr; cmd_phyad[i] = pa; cmd_regad[i] = ra; cmd_wdata[i] = wd;
    cmd_valid[i] = 1'b1;
    n = 0;
    while (cmd_ready[i] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 0, 1);
    @(posedge clk);
  endtask

  // Starts just after the acceptance edge and follows the frame to rsp_valid.
  task automatic watch(input int i, input logic wr, input logic [4:0] pa,
                       input logic [4:0] ra, input logic [15:0] wd, input bit hold,
                       input logic nwr, input logic [4:0] npa, input logic [4:0] nra,
                       input logic [15:0] nwd);
    int d, p, nbits, blen, lat, n, k, b, w, bad;
    logic [2:0] eb [0:64];   // {compare level, release, level}
    logic       resp [0:64];
    logic [15:0] exp_rd;
    logic exp_err, present_phy, done;
    logic [2:0] e;
    d = div_of(i); p = pre_of(i); nbits = p + 33; blen = 2 * d;
    lat = nbits * blen + 1;
    present_phy = (pa == PHY_ADDR);
    n = 0;
    for (int j = 0; j < p; j++) begin eb[n] = 3'b101; n++; end
    eb[n] = 3'b100; n++; eb[n] = 3'b101; n++;
    eb[n] = wr ? 3'b100 : 3'b101; n++; eb[n] = wr ? 3'b101 : 3'b100; n++;
    for (int j = 4; j >= 0; j--) begin eb[n] = {2'b10, pa[j]}; n++; end
    for (int j = 4; j >= 0; j--) begin eb[n] = {2'b10, ra[j]}; n++; end
    eb[n] = wr ? 3'b101 : 3'b010; n++; eb[n] = wr ? 3'b100 : 3'b010; n++;
    for (int j = 15; j >= 0; j--) begin eb[n] = wr ? {2'b10, wd[j]} : 3'b010; n++; end
    eb[n] = 3'b111;
    for (int j = 0; j < 65; j++) resp[j] = 1'b1;
    if (!wr && present_phy) begin
      resp[p + 15] = 1'b0;
      for (int j = 0; j < 16; j++) resp[p + 16 + j] = regs[i][ra][15 - j];
    end
    exp_rd  = wr ? 16'h0000 : (present_phy ? regs[i][ra] : 16'hFFFF);
    exp_err = !wr && !present_phy;
    if (wr && present_phy) regs[i][ra] = wd;
    bad = 0; k = 0; done = 1'b0;
    while (!done && k < lat + 8) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        if (hold) begin
          cmd_write[i] = nwr; cmd_phyad[i] = npa; cmd_regad[i] = nra; cmd_wdata[i] = nwd;
        end else begin
          cmd_valid[i] = 1'b0;
          cmd_write[i] = 1'($urandom); cmd_phyad[i] = 5'($urandom);
          cmd_regad[i] = 5'($urandom); cmd_wdata[i] = 16'($urandom);
        end
      end
      if (rsp_valid[i] === 1'b1) done = 1'b1;
      else if (k <= nbits * blen) begin
        b = (k - 1) / blen; w = (k - 1) % blen;
        e = eb[b];
        if (mdc[i] !== (w >= d)) bad++;
        if (mdio_t[i] !== e[1]) bad++;
        if (e[2] && mdio_o[i] !== e[0]) bad++;
        if (busy[i] !== 1'b1 || cmd_ready[i] !== 1'b0) bad++;
        mdio_i[i] = resp[b];
      end
    end
    mdio_i[i] = 1'b1;
    last_rd[i] = exp_rd;
    check("latency", k, lat);
    check("frame_shape", bad, 0);
    check("rsp_rdata", rsp_rdata[i], exp_rd);
    check("rsp_err", rsp_err[i], exp_err);
    check("done_state", {mdc[i], cmd_ready[i], busy[i]}, 3'b010);
  endtask

  task automatic after(input int i);
    @(negedge clk);
    check("rsp_pulse", rsp_valid[i], 0);
    check("rdata_hold", rsp_rdata[i], last_rd[i]);
  endtask

  task automatic frame(input int i, input logic wr, input logic [4:0] pa,
                       input logic [4:0] ra, input logic [15:0] wd);
    present(i, wr, pa, ra, wd);
    watch(i, wr, pa, ra, wd, 1'b0, 1'b0, 5'd0, 5'd0, 16'd0);
    after(i);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k, i;
    logic wr;
    logic [4:0] pa, ra;
    cmd_valid = '0; cmd_write = '0; cmd_phyad = '0; cmd_regad = '0; cmd_wdata = '0;
    mdio_i = 2'b11;
    for (int x = 0; x < 2; x++)
      for (int j = 0; j < 32; j++) regs[x][j] = 16'($urandom);
    regs[0][2] = 16'hBEEF;
    regs[1][2] = 16'hBEEF;
    repeat (3) @(negedge clk);
    for (int x = 0; x < 2; x++) begin
      check("reset_outs", {mdc[x], mdio_o[x], mdio_t[x], cmd_ready[x], rsp_valid[x], busy[x]},
            6'b011000);
      check("reset_rsp", {rsp_err[x], rsp_rdata[x]}, 17'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 2'b11);

    frame(0, 1'b1, 5'd1, 5'd0, 16'h1234);
    frame(0, 1'b0, 5'd3, 5'd2, 16'h0);
    frame(0, 1'b0, 5'd7, 5'd2, 16'h0);
    frame(1, 1'b0, 5'd3, 5'd2, 16'h0);

    for (int n = 0; n < 10; n++) begin
      i  = int'($urandom_range(0, 1));
      wr = 1'($urandom);
      pa = ($urandom_range(0, 3) != 0) ? PHY_ADDR : 5'($urandom);
      ra = 5'($urandom_range(0, 7));
      frame(i, wr, pa, ra, 16'($urandom));
    end

    // Abort a write in the middle of its data field.
    present(0, 1'b1, PHY_ADDR, 5'd5, 16'hA5A5);
    k = 0;
    while (k < (P0 + 21) * 2 * D0 + 1) begin
      @(negedge clk);
      k++;
      if (k == 1) cmd_valid[0] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_outs", {mdc[0], mdio_o[0], mdio_t[0], busy[0], rsp_valid[0], cmd_ready[0]},
          6'b011000);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_rsp", {rsp_valid[0], cmd_ready[0]}, 2'b01);
    frame(0, 1'b0, PHY_ADDR, 5'd5, 16'h0);

    // Back-to-back commands with cmd_valid held throughout.
    present(1, 1'b1, PHY_ADDR, 5'd6, 16'hC3D2);
    watch(1, 1'b1, PHY_ADDR, 5'd6, 16'hC3D2, 1'b1, 1'b0, PHY_ADDR, 5'd6, 16'h0);
    @(posedge clk);
    watch(1, 1'b0, PHY_ADDR, 5'd6, 16'h0, 1'b0, 1'b0, 5'd0, 5'd0, 16'd0);
    after(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
